rgen_bit_field_rwx: RTL and testbench

RGEN_BIT_FIELD_RWX -- requirements
Module: rgen_bit_field_rwx

---
 rtl/rgen_bit_field_rwx.sv | 94 +++++++++
 tb/tb_rgen_bit_field_rwx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgen_bit_field_rwx.sv
// rgen_bit_field_rwx
// One register field with a selectable software access mode (RW, W1C, W1S,
// RC, RO) and hardware load/set/clear hooks. It provides the current value,
// bus read data, per-bit change pulses and an OR-reduced status bit.
module rgen_bit_field_rwx #(
    parameter int               WIDTH         = 1,
    parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
    parameter int               MODE          = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_command_valid,
    input  logic             i_select,
    input  logic             i_write,
    input  logic [WIDTH-1:0] i_write_data,
    input  logic [WIDTH-1:0] i_write_mask,
    input  logic             i_hw_load,
    input  logic [WIDTH-1:0] i_hw_load_data,
    input  logic [WIDTH-1:0] i_hw_set,
    input  logic [WIDTH-1:0] i_hw_clear,
    output logic [WIDTH-1:0] o_value,
    output logic [WIDTH-1:0] o_read_data,
    output logic [WIDTH-1:0] o_changed,
    output logic             o_any
);

    // Mode decode. Any value outside 1..4 falls back to plain read/write.
    localparam bit IS_W1C = (MODE == 1);
    localparam bit IS_W1S = (MODE == 2);
    localparam bit IS_RC  = (MODE == 3);
    localparam bit IS_RO  = (MODE == 4);

    logic             sw_wr;
    logic             sw_rd;
    logic [WIDTH-1:0] sw_hit;      // bits the software access targets this cycle
    logic [WIDTH-1:0] sw_val;      // value software drives into the targeted bits
    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] value_next;
    logic [WIDTH-1:0] changed_reg;

    assign sw_wr = i_command_valid & i_select & i_write;
    assign sw_rd = i_command_valid & i_select & ~i_write;

    // Translate the bus access into a per-bit target mask and target value.
    always_comb begin
        sw_hit = '0;
        sw_val = '0;
        if (IS_W1C) begin
            sw_hit = {WIDTH{sw_wr}} & i_write_data & i_write_mask;
            sw_val = '0;
        end else if (IS_W1S) begin
            sw_hit = {WIDTH{sw_wr}} & i_write_data & i_write_mask;
            sw_val = '1;
        end else if (IS_RC) begin
            sw_hit = {WIDTH{sw_rd}};
            sw_val = '0;
        end else if (IS_RO) begin
            sw_hit = '0;
            sw_val = '0;
        end else begin
            sw_hit = {WIDTH{sw_wr}} & i_write_mask;
            sw_val = i_write_data;
        end
    end

    // Per-bit next value: load beats set, set beats software, software beats
    // clear, so a hardware set racing a W1C/RC access is never lost.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign value_next[gi] = i_hw_load  ? i_hw_load_data[gi] :
                                    i_hw_set[gi]   ? 1'b1 :
                                    sw_hit[gi]     ? sw_val[gi] :
                                    i_hw_clear[gi] ? 1'b0 :
                                                     value_reg[gi];
        end
    endgenerate

    // Field state and change pulses; reset drops any in-flight update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_reg   <= INITIAL_VALUE;
            changed_reg <= '0;
        end else begin
            value_reg   <= value_next;
            changed_reg <= value_next ^ value_reg;
        end
    end

    assign o_value     = value_reg;
    assign o_read_data = sw_rd ? value_reg : '0;
    assign o_changed   = changed_reg;
    assign o_any       = |value_reg;

endmodule

// File: tb/tb_rgen_bit_field_rwx.sv
// Testbench for rgen_bit_field_rwx: six 8-bit instances (RW, W1C, W1S, RC,
// RO and an out-of-range mode that must act as RW) driven from a vector table,
// with expected post-edge results queued and checked after each clock edge,
// followed by a hand-written asynchronous reset sequence.
module tb_rgen_bit_field_rwx;

    localparam int NI = 6;
    localparam logic [7:0] INIT_TAB [NI] = '{8'h5A, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    localparam int         MODE_TAB [NI] = '{0, 1, 2, 3, 4, 7};

    typedef struct {
        int         inst;
        logic       cv;
        logic       sel;
        logic       wr;
        logic [7:0] wd;
        logic [7:0] wm;
        logic       hl;
        logic [7:0] hld;
        logic [7:0] hs;
        logic [7:0] hc;
        logic [7:0] erd;
        logic [7:0] eval;
        logic [7:0] echg;
        logic       eany;
    } vec_t;

    typedef struct {
        int         row;
        int         inst;
        logic [7:0] eval;
        logic [7:0] echg;
        logic       eany;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       cv  [NI];
    logic       sel [NI];
    logic       wr  [NI];
    logic [7:0] wd  [NI];
    logic [7:0] wm  [NI];
    logic       hl  [NI];
    logic [7:0] hld [NI];
    logic [7:0] hs  [NI];
    logic [7:0] hc  [NI];
    logic [7:0] ov  [NI];
    logic [7:0] ord [NI];
    logic [7:0] och [NI];
    logic       oa  [NI];

    int total;
    int bad;
    vec_t vt[$];
    exp_t sb[$];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            rgen_bit_field_rwx #(
                .WIDTH         (8),
                .INITIAL_VALUE (INIT_TAB[gi]),
                .MODE          (MODE_TAB[gi])
            ) dut (
                .clk             (clk),
                .rst             (rst),
                .i_command_valid (cv[gi]),
                .i_select        (sel[gi]),
                .i_write         (wr[gi]),
                .i_write_data    (wd[gi]),
                .i_write_mask    (wm[gi]),
                .i_hw_load       (hl[gi]),
                .i_hw_load_data  (hld[gi]),
                .i_hw_set        (hs[gi]),
                .i_hw_clear      (hc[gi]),
                .o_value         (ov[gi]),
                .o_read_data     (ord[gi]),
                .o_changed       (och[gi]),
                .o_any           (oa[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            cv[i] = 0; sel[i] = 0; wr[i] = 0; wd[i] = 0; wm[i] = 0;
            hl[i] = 0; hld[i] = 0; hs[i] = 0; hc[i] = 0;
        end
    endtask

    // inst cv sel wr wd wm hl hld hs hc | rd val chg any
    task automatic add(input int inst, input logic c, input logic s, input logic w,
                       input logic [7:0] d, input logic [7:0] m, input logic l,
                       input logic [7:0] ld, input logic [7:0] st, input logic [7:0] cl,
                       input logic [7:0] erd, input logic [7:0] ev, input logic [7:0] ec,
                       input logic ea);
        vt.push_back('{inst, c, s, w, d, m, l, ld, st, cl, erd, ev, ec, ea});
    endtask

    initial begin
        exp_t e;
        total = 0;
        bad   = 0;

        // RW (inst 0, init 5A)
        add(0, 1,1,1, 8'hFF,8'h0F, 0,8'h00, 8'h00,8'h00,  8'h00, 8'h5F, 8'h05, 1);
        add(0, 0,0,0, 8'h00,8'h00, 0,8'h00, 8'h00,8'h00,  8'h00, 8'h5F, 8'h00, 1);
        add(0, 1,1,0, 8'h00,8'h00, 0,8'h00, 8'h00,8'h00,  8'h5F, 8'h5F, 8'h00, 1);
        add(0, 1,1,1, 8'h5F,8'hFF, 0,8'h00, 8'h00,8'h00,  8'h00, 8'h5F, 8'h00, 1);
        add(0, 1,0,1, 8'hFF,8'hFF, 0,8'h00, 8'h00,8'h00,  8'h00, 8'h5F, 8'h00, 1);
        add(0, 1,1,1, 8'h00,8'hFF, 0,8'h00, 8'h01,8'hF0,  8'h00, 8'h01, 8'h5E, 1);
        add(0, 0,0,0, 8'h00,8'h00, 0,8'h00, 8'h00,8'hFF,  8'h00, 8'h00, 8'h01, 0);
        add(0, 1,1,1, 8'h55,8'hFF, 1,8'hAA, 8'h01,8'h00,  8'h00, 8'hAA, 8'hAA, 1);
        add(0, 1,1,1, 8'hF0,8'hF0, 0,8'h00, 8'h00,8'hFF,  8'h00, 8'hF0, 8'h5A, 1);
        // W1C (inst 1)
        add(1, 0,0,0, 8'h00,8'h00, 1,8'hF0, 8'h00,8'h00,  8'h00, 8'hF0, 8'hF0, 1);
        add(1, 1,1,1, 8'h30,8'hFF, 0,8'h00, 8'h10,8'h00,  8'h00, 8'hD0, 8'h20, 1);
        add(1, 1,1,1, 8'hC0,8'h40, 0,8'h00, 8'h00,8'h00,  8'h00, 8'h90, 8'h40, 1);
        add(1, 1,1,0, 8'h00,8'h00, 0,8'h00, 8'h00,8'h00,  8'h90, 8'h90, 8'h00, 1);
        add(1, 1,1,1, 8'hFF,8'hFF, 0,8'h00, 8'h00,8'h00,  8'h00, 8'h00, 8'h90, 0);
        // W1S (inst 2, init 01)
        add(2, 1,1,1, 8'h0F,8'h03, 0,8'h00, 8'h00,8'h00,  8'h00, 8'h03, 8'h02, 1);
        add(2, 1,1,1, 8'hF0,8'hF0, 0,8'h00, 8'h00,8'h03,  8'h00, 8'hF0, 8'hF3, 1);
        add(2, 1,1,1, 8'h01,8'h01, 0,8'h00, 8'h00,8'hFF,  8'h00, 8'h01, 8'hF1, 1);
        // RC (inst 3)
        add(3, 0,0,0, 8'h00,8'h00, 1,8'h81, 8'h00,8'h00,  8'h00, 8'h81, 8'h81, 1);
        add(3, 1,1,1, 8'hFF,8'hFF, 0,8'h00, 8'h00,8'h00,  8'h00, 8'h81, 8'h00, 1);
        add(3, 1,1,0, 8'h00,8'h00, 0,8'h00, 8'h00,8'h00,  8'h81, 8'h00, 8'h81, 0);
        add(3, 1,1,0, 8'h00,8'h00, 0,8'h00, 8'h00,8'h00,  8'h00, 8'h00, 8'h00, 0);
        add(3, 0,0,0, 8'h00,8'h00, 1,8'h0F, 8'h00,8'h00,  8'h00, 8'h0F, 8'h0F, 1);
        add(3, 1,1,0, 8'h00,8'h00, 0,8'h00, 8'h02,8'h00,  8'h0F, 8'h02, 8'h0D, 1);
        // RO (inst 4)
        add(4, 1,1,1, 8'hFF,8'hFF, 0,8'h00, 8'h00,8'h00,  8'h00, 8'h00, 8'h00, 0);
        add(4, 0,0,0, 8'h00,8'h00, 1,8'h3C, 8'h00,8'hFF,  8'h00, 8'h3C, 8'h3C, 1);
        add(4, 1,1,0, 8'h00,8'h00, 0,8'h00, 8'h00,8'h00,  8'h3C, 8'h3C, 8'h00, 1);
        add(4, 1,1,1, 8'h00,8'hFF, 0,8'h00, 8'h00,8'h04,  8'h00, 8'h38, 8'h04, 1);
        // Out-of-range mode 7 behaves as RW (inst 5)
        add(5, 1,1,1, 8'hA5,8'hFF, 0,8'h00, 8'h00,8'h00,  8'h00, 8'hA5, 8'hA5, 1);
        add(5, 1,1,0, 8'h00,8'h00, 0,8'h00, 8'h00,8'h00,  8'hA5, 8'hA5, 8'h00, 1);
        // W1S write just before the reset sequence
        add(2, 1,1,1, 8'h10,8'h10, 0,8'h00, 8'h00,8'h00,  8'h00, 8'h11, 8'h10, 1);

        // Reset state, checked with no clock edge dependence
        idle_all();
        rst = 1'b1;
        #3;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_value[%0d]", i), ov[i], INIT_TAB[i]);
            chk($sformatf("reset_changed[%0d]", i), och[i], 8'h00);
            chk($sformatf("reset_read[%0d]", i), ord[i], 8'h00);
        end
        $display("reset: initial values checked");

        @(negedge clk);
        rst = 1'b0;

        foreach (vt[r]) begin
            idle_all();
            cv[vt[r].inst]  = vt[r].cv;
            sel[vt[r].inst] = vt[r].sel;
            wr[vt[r].inst]  = vt[r].wr;
            wd[vt[r].inst]  = vt[r].wd;
            wm[vt[r].inst]  = vt[r].wm;
            hl[vt[r].inst]  = vt[r].hl;
            hld[vt[r].inst] = vt[r].hld;
            hs[vt[r].inst]  = vt[r].hs;
            hc[vt[r].inst]  = vt[r].hc;
            #1;
            chk($sformatf("row%0d_read_data", r), ord[vt[r].inst], vt[r].erd);
            sb.push_back('{r, vt[r].inst, vt[r].eval, vt[r].echg, vt[r].eany});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("row%0d_value", e.row), ov[e.inst], e.eval);
            chk($sformatf("row%0d_changed", e.row), och[e.inst], e.echg);
            chk($sformatf("row%0d_any", e.row), {7'd0, oa[e.inst]}, {7'd0, e.eany});
            $display("row %0d inst %0d: value=%h changed=%h any=%0d", e.row, e.inst,
                     ov[e.inst], och[e.inst], oa[e.inst]);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a W1S write of 80
        idle_all();
        cv[2] = 1; sel[2] = 1; wr[2] = 1; wd[2] = 8'h80; wm[2] = 8'h80;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_value", ov[2], 8'h01);
        chk("async_rst_changed", och[2], 8'h00);
        chk("async_rst_other_value", ov[0], 8'h5A);
        chk("async_rst_other_value3", ov[3], 8'h00);
        $display("reset asserted mid-write: value=%h changed=%h", ov[2], och[2]);
        @(posedge clk);
        #1;
        chk("rst_held_value", ov[2], 8'h01);
        chk("rst_held_changed", och[2], 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_write_value", ov[2], 8'h81);
        chk("post_rst_write_changed", och[2], 8'h80);
        $display("first write after reset: value=%h changed=%h", ov[2], och[2]);
        @(negedge clk);
        idle_all();
        @(posedge clk);
        #1;
        chk("post_rst_pulse_end", och[2], 8'h00);
        chk("post_rst_hold", ov[2], 8'h81);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
